// File: rtl/bram_burst_writer_pkg.sv
// Shared types and constants for the BRAM burst writer and its callers.
package bram_burst_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PAGE_REQ  = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_CYCLE     = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_SETUP = 2'd1,
    PH_WE    = 2'd2,
    PH_HOLD  = 2'd3
  } phase_e;

  localparam logic [1:0]  BRAM_SELECT_CONTROLLER = 2'b00;

  // Controller addresses of the page registers known to callers.
  localparam logic [13:0] PAGE_REG_ADDR_STM = 14'h0042;
  localparam logic [13:0] PAGE_REG_ADDR_DMA = 14'h0043;

endpackage

// File: rtl/bram_burst_writer_if.sv
// Command, word-stream and memory-bus bundle of the burst writer.
interface bram_burst_writer_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 14,
  parameter int SELECT_WIDTH = 2,
  parameter int PAGE_WIDTH   = 4,
  parameter int LEN_WIDTH    = 16
) ();
  logic                             CMD_VALID;
  logic                             CMD_READY;
  logic [SELECT_WIDTH-1:0]          CMD_SELECT;
  logic [PAGE_WIDTH+ADDR_WIDTH-1:0] CMD_INDEX;
  logic [LEN_WIDTH-1:0]             CMD_LEN;
  logic                             CMD_PAGED;
  logic [ADDR_WIDTH-1:0]            CMD_PAGE_REG;
  logic                             DATA_VALID;
  logic                             DATA_READY;
  logic [DATA_WIDTH-1:0]            DATA_IN;
  logic                             EN;
  logic                             WE;
  logic [SELECT_WIDTH-1:0]          BRAM_SELECT;
  logic [ADDR_WIDTH-1:0]            BRAM_ADDR;
  logic [DATA_WIDTH-1:0]            DATA_OUT;
  logic                             BUSY;
  logic                             DONE;

  // Burst writer side
  modport master (
    input  CMD_VALID, CMD_SELECT, CMD_INDEX, CMD_LEN, CMD_PAGED, CMD_PAGE_REG,
    input  DATA_VALID, DATA_IN,
    output CMD_READY, DATA_READY,
    output EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_OUT, BUSY, DONE
  );

  // Loader / bus observer side
  modport slave (
    output CMD_VALID, CMD_SELECT, CMD_INDEX, CMD_LEN, CMD_PAGED, CMD_PAGE_REG,
    output DATA_VALID, DATA_IN,
    input  CMD_READY, DATA_READY,
    input  EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_OUT, BUSY, DONE
  );
endinterface

// File: rtl/bram_burst_writer_write_cycle.sv
// One three-phase BRAM write cycle: setup, write strobe, hold.
module bram_write_cycle
  import bram_burst_writer_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int WE_CYCLES    = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic en_o,
  output logic we_o,
  output logic done_o
);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] WE_LAST    = 8'(WE_CYCLES - 1);

  phase_e     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;

  // Phase register and per-phase cycle counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Phase sequencing: start launches setup, hold is the final cycle
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (phase_q)
      PH_IDLE: begin
        if (start_i) begin
          phase_d = PH_SETUP;
          cnt_d   = '0;
        end
      end
      PH_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          phase_d = PH_WE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PH_WE: begin
        if (cnt_q == WE_LAST) begin
          phase_d = PH_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PH_HOLD: phase_d = PH_IDLE;
      default: phase_d = PH_IDLE;
    endcase
  end

  assign en_o   = (phase_q != PH_IDLE);
  assign we_o   = (phase_q == PH_WE);
  assign done_o = (phase_q == PH_HOLD);

endmodule

// File: rtl/bram_burst_writer.sv
// Burst write master: command + word stream to paged BRAM write cycles.
module bram_burst_writer
  import bram_burst_writer_pkg::*;
#(
  parameter int                      DATA_WIDTH   = 16,
  parameter int                      ADDR_WIDTH   = 14,
  parameter int                      SELECT_WIDTH = 2,
  parameter int                      PAGE_WIDTH   = 4,
  parameter int                      SETUP_CYCLES = 1,
  parameter int                      WE_CYCLES    = 2,
  parameter logic [SELECT_WIDTH-1:0] CTRL_SELECT  = BRAM_SELECT_CONTROLLER,
  parameter int                      LEN_WIDTH    = 16
) (
  input logic                CLK,
  input logic                RST,
  bram_burst_writer_if.master bus
);
  localparam int IW = PAGE_WIDTH + ADDR_WIDTH;

  state_e                  state_q, state_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [IW-1:0]           idx_q, idx_d, idx_inc;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic                    paged_q, paged_d;
  logic [ADDR_WIDTH-1:0]   preg_q, preg_d;
  logic [SELECT_WIDTH-1:0] bsel_q, bsel_d;
  logic [ADDR_WIDTH-1:0]   baddr_q, baddr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    cyc_start, cyc_en, cyc_we, cyc_done;

  bram_write_cycle #(
    .SETUP_CYCLES(SETUP_CYCLES),
    .WE_CYCLES   (WE_CYCLES)
  ) u_cycle (
    .clk_i  (CLK),
    .rst_i  (RST),
    .start_i(cyc_start),
    .en_o   (cyc_en),
    .we_o   (cyc_we),
    .done_o (cyc_done)
  );

  // Burst state, latched command and registered bus fields
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      paged_q <= 1'b0;
      preg_q  <= '0;
      bsel_q  <= '0;
      baddr_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      paged_q <= paged_d;
      preg_q  <= preg_d;
      bsel_q  <= bsel_d;
      baddr_q <= baddr_d;
      dout_q  <= dout_d;
    end
  end

  // Burst sequencing; bus fields are loaded together with the cycle start
  // so they stay constant through every phase of that cycle.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    paged_d   = paged_q;
    preg_d    = preg_q;
    bsel_d    = bsel_q;
    baddr_d   = baddr_q;
    dout_d    = dout_q;
    cyc_start = 1'b0;
    idx_inc   = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.CMD_VALID) begin
          sel_d   = bus.CMD_SELECT;
          idx_d   = bus.CMD_INDEX;
          rem_d   = bus.CMD_LEN;
          paged_d = bus.CMD_PAGED;
          preg_d  = bus.CMD_PAGE_REG;
          if (bus.CMD_LEN == '0)  state_d = ST_FINISH;
          else if (bus.CMD_PAGED) state_d = ST_PAGE_REQ;
          else                    state_d = ST_WAIT_DATA;
        end
      end
      ST_PAGE_REQ: begin
        // Entry cycle keeps EN low; the page write starts from it.
        if (!cyc_en) begin
          cyc_start = 1'b1;
          bsel_d    = CTRL_SELECT;
          baddr_d   = preg_q;
          dout_d    = '0;
          dout_d[PAGE_WIDTH-1:0] = idx_q[IW-1:ADDR_WIDTH];
        end
        if (cyc_done) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (bus.DATA_VALID) begin
          cyc_start = 1'b1;
          bsel_d    = sel_q;
          baddr_d   = idx_q[ADDR_WIDTH-1:0];
          dout_d    = bus.DATA_IN;
          state_d   = ST_CYCLE;
        end
      end
      ST_CYCLE: begin
        if (cyc_done) begin
          if (paged_q) idx_inc = idx_q + IW'(1);
          else idx_inc = {idx_q[IW-1:ADDR_WIDTH], idx_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1)};
          idx_d = idx_inc;
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1))                      state_d = ST_FINISH;
          else if (paged_q && idx_inc[ADDR_WIDTH-1:0] == '0) state_d = ST_PAGE_REQ;
          else                                             state_d = ST_WAIT_DATA;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign bus.CMD_READY   = (state_q == ST_IDLE);
  assign bus.DATA_READY  = (state_q == ST_WAIT_DATA);
  assign bus.BUSY        = (state_q != ST_IDLE);
  assign bus.DONE        = (state_q == ST_FINISH);
  assign bus.EN          = cyc_en;
  assign bus.WE          = cyc_we;
  assign bus.BRAM_SELECT = bsel_q;
  assign bus.BRAM_ADDR   = baddr_q;
  assign bus.DATA_OUT    = dout_q;

endmodule

// File: tb/tb_bram_burst_writer.sv
// Directed self-checking bench for bram_burst_writer.
module tb_bram_burst_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_burst_writer_if bus ();

  bram_burst_writer dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    int sel;
    int addr;
    int data;
    int we;
    int len;
    int start;
    bit stable;
  } wr_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  wr_t wr_q[$];
  wr_t cur;
  bit in_cyc = 0;
  int done_cnt = 0;
  int en_cnt = 0;
  logic [15:0] data_q[$];
  int stall_gap = 0;
  int stall_left = 0;
  bit took = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus recorder: one record per EN-high window
  initial begin
    forever begin
      @(negedge clk);
      if (bus.EN === 1'b1) begin
        en_cnt++;
        if (!in_cyc) begin
          in_cyc = 1;
          cur.sel = int'(bus.BRAM_SELECT);
          cur.addr = int'(bus.BRAM_ADDR);
          cur.data = int'(bus.DATA_OUT);
          cur.we = 0;
          cur.len = 0;
          cur.start = cyc;
          cur.stable = 1;
        end else if (cur.sel != int'(bus.BRAM_SELECT) || cur.addr != int'(bus.BRAM_ADDR) ||
                     cur.data != int'(bus.DATA_OUT)) begin
          cur.stable = 0;
        end
        cur.len++;
        if (bus.WE === 1'b1) cur.we++;
      end else if (in_cyc) begin
        in_cyc = 0;
        wr_q.push_back(cur);
      end
      if (bus.DONE === 1'b1) done_cnt++;
      took = (bus.DATA_VALID === 1'b1) && (bus.DATA_READY === 1'b1);
    end
  end

  // Word-stream source with optional idle gap after each accepted word
  initial begin
    bus.DATA_VALID = 1'b0;
    bus.DATA_IN = '0;
    forever begin
      @(posedge clk);
      #1;
      if (took && data_q.size() > 0) begin
        void'(data_q.pop_front());
        stall_left = stall_gap;
      end
      if (stall_left > 0) begin
        bus.DATA_VALID = 1'b0;
        stall_left--;
      end else if (data_q.size() > 0) begin
        bus.DATA_VALID = 1'b1;
        bus.DATA_IN = data_q[0];
      end else begin
        bus.DATA_VALID = 1'b0;
      end
    end
  end

  task automatic issue_cmd(input logic [1:0] sel, input logic [17:0] idx, input logic [15:0] len,
                           input logic paged, input logic [13:0] preg, input bit hold,
                           output int acc);
    bus.CMD_SELECT = sel;
    bus.CMD_INDEX = idx;
    bus.CMD_LEN = len;
    bus.CMD_PAGED = paged;
    bus.CMD_PAGE_REG = preg;
    bus.CMD_VALID = 1'b1;
    acc = -1000;
    for (int i = 0; i < 100; i++) begin
      if (bus.CMD_READY === 1'b1) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (!hold) bus.CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -100000;
    for (int i = 0; i < 200; i++) begin
      if (bus.DONE === 1'b1) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", bus.EN); end
    checks++; if (bus.WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.WE); end
    checks++; if (bus.BRAM_SELECT !== 2'd0) begin errors++; $display("FAIL reset_sel: got %h expected 0", bus.BRAM_SELECT); end
    checks++; if (bus.BRAM_ADDR !== 14'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.BRAM_ADDR); end
    checks++; if (bus.DATA_OUT !== 16'd0) begin errors++; $display("FAIL reset_dout: got %h expected 0", bus.DATA_OUT); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.DONE); end
    checks++; if (bus.DATA_READY !== 1'b0) begin errors++; $display("FAIL reset_dready: got %b expected 0", bus.DATA_READY); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.CMD_READY !== 1'b1) begin errors++; $display("FAIL reset_cready: got %b expected 1", bus.CMD_READY); end
  endtask

  task automatic test_reset_mid_burst();
    int acc, d0;
    bit seen_we;
    data_q = '{16'h1111, 16'h2222, 16'h3333};
    issue_cmd(2'd1, 18'h00020, 16'd3, 1'b0, 14'h0, 1'b0, acc);
    seen_we = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.WE === 1'b1) begin seen_we = 1; break; end
      @(negedge clk);
    end
    checks++; if (!seen_we) begin errors++; $display("FAIL midrst_we_seen: got 0 expected 1"); end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.EN !== 1'b0 || bus.WE !== 1'b0) begin errors++; $display("FAIL midrst_en_we: got en=%b we=%b expected 0 0", bus.EN, bus.WE); end
    rst = 1'b0;
    data_q.delete();
    repeat (20) @(negedge clk);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midrst_no_done: got %0d done pulses expected 0", done_cnt - d0); end
    checks++; if (bus.CMD_READY !== 1'b1 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL midrst_idle: got ready=%b busy=%b expected 1 0", bus.CMD_READY, bus.BUSY); end
    wr_q.delete();
  endtask

  task automatic test_unpaged();
    int acc, d;
    wr_q.delete();
    data_q = '{16'hA001, 16'hA002, 16'hA003};
    issue_cmd(2'd1, 18'h00010, 16'd3, 1'b0, 14'h0, 1'b0, acc);
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL unpaged_busy: got %b expected 1", bus.BUSY); end
    wait_done(d);
    @(negedge clk);
    checks++; if (d - acc !== 16) begin errors++; $display("FAIL unpaged_done_lat: got %0d expected 16", d - acc); end
    checks++; if (wr_q.size() !== 3) begin errors++; $display("FAIL unpaged_count: got %0d expected 3", wr_q.size()); end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].sel != 1 || wr_q[i].addr != 16'h10 + i || wr_q[i].data != 16'hA001 + i ||
          wr_q[i].we != 2 || wr_q[i].len != 4 || !wr_q[i].stable || wr_q[i].start != acc + 2 + 5 * i) begin
        errors++;
        $display("FAIL unpaged_wr%0d: got sel=%0h addr=%0h data=%0h we=%0d len=%0d stable=%0d start=%0d expected sel=1 addr=%0h data=%0h we=2 len=4 stable=1 start=%0d",
                 i, wr_q[i].sel, wr_q[i].addr, wr_q[i].data, wr_q[i].we, wr_q[i].len, wr_q[i].stable,
                 wr_q[i].start, 16'h10 + i, 16'hA001 + i, acc + 2 + 5 * i);
      end
    end
  endtask

  task automatic test_paged_crossing();
    int acc, d;
    int e_sel[6]  = '{0, 3, 3, 0, 3, 3};
    int e_addr[6] = '{'h42, 'h3FFE, 'h3FFF, 'h42, 'h0000, 'h0001};
    int e_data[6] = '{'h0000, 'hC001, 'hC002, 'h0001, 'hC003, 'hC004};
    wr_q.delete();
    data_q = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
    issue_cmd(2'd3, 18'h03FFE, 16'd4, 1'b1, 14'h0042, 1'b0, acc);
    wait_done(d);
    @(negedge clk);
    checks++; if (d - acc !== 31) begin errors++; $display("FAIL paged_done_lat: got %0d expected 31", d - acc); end
    checks++; if (wr_q.size() !== 6) begin errors++; $display("FAIL paged_count: got %0d expected 6", wr_q.size()); end
    for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].sel != e_sel[i] || wr_q[i].addr != e_addr[i] || wr_q[i].data != e_data[i] ||
          wr_q[i].we != 2 || wr_q[i].len != 4 || !wr_q[i].stable || wr_q[i].start != acc + 2 + 5 * i) begin
        errors++;
        $display("FAIL paged_wr%0d: got sel=%0h addr=%0h data=%0h we=%0d len=%0d stable=%0d start=%0d expected sel=%0h addr=%0h data=%0h we=2 len=4 stable=1 start=%0d",
                 i, wr_q[i].sel, wr_q[i].addr, wr_q[i].data, wr_q[i].we, wr_q[i].len, wr_q[i].stable,
                 wr_q[i].start, e_sel[i], e_addr[i], e_data[i], acc + 2 + 5 * i);
      end
    end
  endtask

  task automatic test_len_zero();
    int acc, d, e0;
    wr_q.delete();
    e0 = en_cnt;
    issue_cmd(2'd2, 18'h00100, 16'd0, 1'b1, 14'h0042, 1'b0, acc);
    wait_done(d);
    repeat (3) @(negedge clk);
    checks++; if (d - acc !== 1) begin errors++; $display("FAIL len0_done_lat: got %0d expected 1", d - acc); end
    checks++; if (en_cnt !== e0) begin errors++; $display("FAIL len0_en: got %0d EN cycles expected 0", en_cnt - e0); end
    checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL len0_writes: got %0d expected 0", wr_q.size()); end
  endtask

  task automatic test_stall();
    int acc, d, e0;
    wr_q.delete();
    e0 = en_cnt;
    stall_gap = 10;
    data_q = '{16'hB001, 16'hB002, 16'hB003};
    issue_cmd(2'd2, 18'h00100, 16'd3, 1'b0, 14'h0, 1'b0, acc);
    wait_done(d);
    @(negedge clk);
    stall_gap = 0;
    checks++; if (d - acc !== 28) begin errors++; $display("FAIL stall_done_lat: got %0d expected 28", d - acc); end
    checks++; if (en_cnt - e0 !== 12) begin errors++; $display("FAIL stall_en_cycles: got %0d expected 12", en_cnt - e0); end
    checks++; if (wr_q.size() !== 3) begin errors++; $display("FAIL stall_count: got %0d expected 3", wr_q.size()); end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].sel != 2 || wr_q[i].addr != 'h100 + i || wr_q[i].data != 'hB001 + i ||
          wr_q[i].we != 2 || wr_q[i].len != 4 || !wr_q[i].stable || wr_q[i].start != acc + 2 + 11 * i) begin
        errors++;
        $display("FAIL stall_wr%0d: got sel=%0h addr=%0h data=%0h we=%0d len=%0d stable=%0d start=%0d expected sel=2 addr=%0h data=%0h we=2 len=4 stable=1 start=%0d",
                 i, wr_q[i].sel, wr_q[i].addr, wr_q[i].data, wr_q[i].we, wr_q[i].len, wr_q[i].stable,
                 wr_q[i].start, 'h100 + i, 'hB001 + i, acc + 2 + 11 * i);
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, d1, d2;
    bit ready_bad;
    int e_sel[5]  = '{0, 1, 0, 1, 2};
    int e_addr[5] = '{'h42, 'h3FFF, 'h42, 'h0000, 'h0005};
    int e_data[5] = '{'h000F, 'hE001, 'h0000, 'hE002, 'hE003};
    int e_start[5];
    wr_q.delete();
    data_q = '{16'hE001, 16'hE002, 16'hE003};
    issue_cmd(2'd1, 18'h3FFFF, 16'd2, 1'b1, 14'h0042, 1'b1, acc1);
    bus.CMD_SELECT = 2'd2;
    bus.CMD_INDEX = 18'h00005;
    bus.CMD_LEN = 16'd1;
    bus.CMD_PAGED = 1'b0;
    bus.CMD_PAGE_REG = 14'h0;
    ready_bad = 0;
    d1 = -100000;
    for (int i = 0; i < 100; i++) begin
      if (bus.CMD_READY !== 1'b0) ready_bad = 1;
      if (bus.DONE === 1'b1) begin d1 = cyc; break; end
      @(negedge clk);
    end
    checks++; if (ready_bad) begin errors++; $display("FAIL b2b_ready_held_off: got 1 expected 0 before end of DONE"); end
    checks++; if (d1 - acc1 !== 21) begin errors++; $display("FAIL b2b_done1_lat: got %0d expected 21", d1 - acc1); end
    @(negedge clk);
    acc2 = cyc;
    checks++; if (bus.CMD_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %b expected 1", bus.CMD_READY); end
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    wait_done(d2);
    @(negedge clk);
    checks++; if (d2 - acc2 !== 6) begin errors++; $display("FAIL b2b_done2_lat: got %0d expected 6", d2 - acc2); end
    e_start = '{acc1 + 2, acc1 + 7, acc1 + 12, acc1 + 17, acc2 + 2};
    checks++; if (wr_q.size() !== 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", wr_q.size()); end
    for (int i = 0; i < 5 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].sel != e_sel[i] || wr_q[i].addr != e_addr[i] || wr_q[i].data != e_data[i] ||
          wr_q[i].we != 2 || wr_q[i].len != 4 || !wr_q[i].stable || wr_q[i].start != e_start[i]) begin
        errors++;
        $display("FAIL b2b_wr%0d: got sel=%0h addr=%0h data=%0h we=%0d len=%0d stable=%0d start=%0d expected sel=%0h addr=%0h data=%0h we=2 len=4 stable=1 start=%0d",
                 i, wr_q[i].sel, wr_q[i].addr, wr_q[i].data, wr_q[i].we, wr_q[i].len, wr_q[i].stable,
                 wr_q[i].start, e_sel[i], e_addr[i], e_data[i], e_start[i]);
      end
    end
  endtask

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_SELECT = '0;
    bus.CMD_INDEX = '0;
    bus.CMD_LEN = '0;
    bus.CMD_PAGED = 1'b0;
    bus.CMD_PAGE_REG = '0;
    test_reset();
    test_reset_mid_burst();
    test_unpaged();
    test_paged_crossing();
    test_len_zero();
    test_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_burst_writer.md
# bram_burst_writer

Synthesizable memory-bus master that turns a burst-write command plus a valid/ready word stream into back-to-back CPU-style BRAM write cycles on the FPGA memory bus. It generalises the single-word host write into parametrised bursts with auto-incrementing addresses and automatic page-register updates when the burst crosses a page boundary. It sits between an on-chip loader (self-test, boot image, DMA) and the memory bus arbiter. Its outputs have the same meaning as the EN/WE/BRAM_SELECT/BRAM_ADDR/DATA_IN bus fields.

## Interface
Parameters
- DATA_WIDTH, 16: bus data width.
- ADDR_WIDTH, 14: in-page word address width.
- SELECT_WIDTH, 2: BRAM select width.
- PAGE_WIDTH, 4: page register width. A full word index is PAGE_WIDTH+ADDR_WIDTH bits.
- SETUP_CYCLES, 1: cycles with EN=1, WE=0 before the strobe. Must be ≥1.
- WE_CYCLES, 2: cycles with WE=1. Must be ≥1.
- CTRL_SELECT, 2'b00: select value of the controller BRAM.
- LEN_WIDTH, 16: burst length counter width.

Ports
- CLK  in  1  sole clock.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  high only in IDLE.
- CMD_SELECT  in  SELECT_WIDTH  target BRAM.
- CMD_INDEX  in  PAGE_WIDTH+ADDR_WIDTH  start word index.
- CMD_LEN  in  LEN_WIDTH  word count; 0 is legal.
- CMD_PAGED  in  1  enables page-register writes.
- CMD_PAGE_REG  in  ADDR_WIDTH  controller address of the page register.
- DATA_VALID  in  1  / DATA_READY  out  1  / DATA_IN  in  DATA_WIDTH  word stream.
- EN  out  1 / WE  out  1 / BRAM_SELECT  out  SELECT_WIDTH / BRAM_ADDR  out  ADDR_WIDTH / DATA_OUT  out  DATA_WIDTH  bus drive.
- BUSY  out  1  high from command accept until DONE.
- DONE  out  1  single-cycle completion pulse.

## Operation
- The command is accepted on CMD_VALID && CMD_READY. The block latches select, index, len, paged and page_reg.
- FSM states: IDLE, PAGE_REQ, WAIT_DATA, CYCLE, FINISH.
- IDLE → FINISH when len==0. No bus activity occurs.
- IDLE → PAGE_REQ when paged. This issues a controller write of {0, page} to CMD_PAGE_REG.
- IDLE → WAIT_DATA otherwise. PAGE_REQ also goes to WAIT_DATA once its write cycle completes.
- WAIT_DATA holds DATA_READY=1. A word is taken on DATA_VALID, registered, and the FSM enters CYCLE at {select, offset}.
- CYCLE completion: decrement remaining count and increment the index modulo 2^(PAGE_WIDTH+ADDR_WIDTH).
  - remaining==0 → FINISH.
  - paged and the new offset==0 → PAGE_REQ, carrying the new page. Page wraps from 2^PAGE_WIDTH−1 to 0.
  - otherwise → WAIT_DATA.
- When not paged, the offset wraps within ADDR_WIDTH and the page is ignored.
- FINISH pulses DONE for one cycle, then returns to IDLE.
- A command offered while BUSY is held off (CMD_READY=0). It is not dropped.
- RST in any state returns the FSM to IDLE and abandons the burst. DONE does not pulse.

## Timing
- Reset values at the first edge with RST=1:
  - EN=0, WE=0, BRAM_SELECT=0, BRAM_ADDR=0, DATA_OUT=0.
  - BUSY=0, DONE=0, DATA_READY=0, CMD_READY=1 after RST deasserts.
- Every write cycle, data or page, has three phases:
  - SETUP_CYCLES with EN=1, WE=0.
  - WE_CYCLES with EN=1, WE=1.
  - 1 hold cycle with EN=1, WE=0.
- With defaults a write cycle is 4 cycles.
- BRAM_SELECT, BRAM_ADDR and DATA_OUT are stable through all phases of a cycle.
- EN=0 for at least 1 cycle between write cycles. This is the WAIT_DATA/PAGE_REQ entry cycle.
- Default throughput with DATA_VALID held high: 1 word per 5 cycles.
- Latency:
  - command accept → first EN: 2 cycles.
  - last hold → DONE: 1 cycle.
  - len==0 accept → DONE: 1 cycle.
- DATA_READY is asserted only in WAIT_DATA. Words are never accepted during CYCLE or PAGE_REQ.

## Structure
- A shared package holds the FSM state enum and the write-cycle phase enum.
- The package also holds `BRAM_SELECT_CONTROLLER` and the page-register address constants used by callers.
- One sub-module, bram_write_cycle, generates a single three-phase write cycle from a start pulse and signals done. It is shared by the data and page paths.

## Test plan
- Reset mid-burst: RST during WE=1 → EN/WE low on the next edge, no DONE. A new command then completes normally.
- Unpaged burst, select=1, index=0x0010, len=3, data 0xA001..0xA003, DATA_VALID=1 → three cycles at addr 0x10..0x12. WE high 2 cycles each, DONE 16 cycles after accept.
- Paged crossing, select=3, index=0x03FFE, len=4, CMD_PAGE_REG=0x0042:
  - controller write 0x0000 first, then stm addr 0x3FFE, 0x3FFF.
  - controller write 0x0001, then addr 0x0000, 0x0001.
- len=0 → DONE one cycle after accept, EN never high.
- Stalled stream (DATA_VALID low 10 cycles between words) → EN stays 0 and no address advance while stalled. Final count is correct.
- CMD_VALID held during a burst → CMD_READY=0 until the cycle after DONE, then the second command is accepted. Index wrap 0x3FFFF→0x00000 writes page 0.
